// File: rtl/settings_controller.sv
// Button-driven configuration sequencer: pick a target (time/date/alarm/timer),
// edit its fields with range-checked wrap-around, and commit with one strobe.
module settings_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_cancel,
    input  logic [7:0]  current_24_hour,
    input  logic [7:0]  current_24_min,
    input  logic [7:0]  current_24_sec,
    input  logic [7:0]  current_day,
    input  logic [7:0]  current_month,
    input  logic [15:0] current_year,
    output logic        set_time,
    output logic        set_date,
    output logic        set_alarm,
    output logic        set_timer,
    output logic [7:0]  input_hour,
    output logic [7:0]  input_min,
    output logic [7:0]  input_sec,
    output logic [7:0]  input_day,
    output logic [7:0]  input_month,
    output logic [15:0] input_year,
    output logic [7:0]  alarm_time_hour,
    output logic [7:0]  alarm_time_min,
    output logic [7:0]  alarm_time_sec,
    output logic [7:0]  timer_input_min,
    output logic [7:0]  timer_input_sec,
    output logic [1:0]  edit_target,
    output logic [1:0]  edit_field,
    output logic        editing
);

    typedef enum logic [1:0] {IDLE, SELECT, EDIT, COMMIT} state_t;

    localparam logic [1:0] TGT_TIME  = 2'd0;
    localparam logic [1:0] TGT_DATE  = 2'd1;
    localparam logic [1:0] TGT_ALARM = 2'd2;
    localparam logic [1:0] TGT_TIMER = 2'd3;

    state_t      state;
    logic [15:0] field_val;
    logic [15:0] field_lo;
    logic [15:0] field_hi;
    logic [15:0] stepped;
    logic        last_field;

    // Value and legal range of the field currently under edit.
    always_comb begin
        field_val = '0;
        field_lo  = '0;
        field_hi  = '0;
        case (edit_target)
            TGT_DATE: begin
                case (edit_field)
                    2'd0: begin
                        field_val = {8'd0, input_day};
                        field_lo  = 16'd1;
                        field_hi  = 16'd31;
                    end
                    2'd1: begin
                        field_val = {8'd0, input_month};
                        field_lo  = 16'd1;
                        field_hi  = 16'd12;
                    end
                    default: begin
                        field_val = input_year;
                        field_lo  = 16'd2000;
                        field_hi  = 16'd2099;
                    end
                endcase
            end
            TGT_TIMER: begin
                if (edit_field == 2'd0) begin
                    field_val = {8'd0, input_min};
                    field_hi  = 16'd10;
                end else begin
                    field_val = {8'd0, input_sec};
                    field_hi  = 16'd59;
                end
            end
            default: begin
                case (edit_field)
                    2'd0: begin
                        field_val = {8'd0, input_hour};
                        field_hi  = 16'd23;
                    end
                    2'd1: begin
                        field_val = {8'd0, input_min};
                        field_hi  = 16'd59;
                    end
                    default: begin
                        field_val = {8'd0, input_sec};
                        field_hi  = 16'd59;
                    end
                endcase
            end
        endcase
        last_field = (edit_target == TGT_TIMER) ? (edit_field == 2'd1) : (edit_field == 2'd2);
    end

    // Out-of-range preloads snap to the maximum; otherwise step with wrap.
    // inc outranks dec, so a simultaneous press counts as inc.
    always_comb begin
        stepped = field_hi;
        if (field_val >= field_lo && field_val <= field_hi) begin
            if (btn_inc)
                stepped = (field_val == field_hi) ? field_lo : field_val + 16'd1;
            else
                stepped = (field_val == field_lo) ? field_hi : field_val - 16'd1;
        end
    end

    // NOTE: every register here is updated with <= so all outputs move together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            edit_target     <= TGT_TIME;
            edit_field      <= 2'd0;
            editing         <= 1'b0;
            set_time        <= 1'b0;
            set_date        <= 1'b0;
            set_alarm       <= 1'b0;
            set_timer       <= 1'b0;
            input_hour      <= 8'd0;
            input_min       <= 8'd0;
            input_sec       <= 8'd0;
            input_day       <= 8'd1;
            input_month     <= 8'd1;
            input_year      <= 16'd2020;
            alarm_time_hour <= 8'd0;
            alarm_time_min  <= 8'd0;
            alarm_time_sec  <= 8'd0;
            timer_input_min <= 8'd0;
            timer_input_sec <= 8'd0;
        end else begin
            set_time  <= 1'b0;
            set_date  <= 1'b0;
            set_alarm <= 1'b0;
            set_timer <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_mode) begin
                        state       <= SELECT;
                        edit_target <= TGT_TIME;
                        edit_field  <= 2'd0;
                        editing     <= 1'b1;
                    end
                end
                SELECT: begin
                    if (btn_cancel) begin
                        state   <= IDLE;
                        editing <= 1'b0;
                    end else if (btn_next) begin
                        state      <= EDIT;
                        edit_field <= 2'd0;
                        case (edit_target)
                            TGT_TIME: begin
                                input_hour <= current_24_hour;
                                input_min  <= current_24_min;
                                input_sec  <= current_24_sec;
                            end
                            TGT_DATE: begin
                                input_day   <= current_day;
                                input_month <= current_month;
                                input_year  <= current_year;
                            end
                            TGT_ALARM: begin
                                input_hour <= alarm_time_hour;
                                input_min  <= alarm_time_min;
                                input_sec  <= alarm_time_sec;
                            end
                            default: begin
                                input_min <= timer_input_min;
                                input_sec <= timer_input_sec;
                            end
                        endcase
                    end else if (btn_mode) begin
                        edit_target <= edit_target + 2'd1;
                    end
                end
                EDIT: begin
                    if (btn_cancel) begin
                        state      <= IDLE;
                        edit_field <= 2'd0;
                        editing    <= 1'b0;
                    end else if (btn_next) begin
                        if (last_field) begin
                            state     <= COMMIT;
                            editing   <= 1'b0;
                            set_time  <= (edit_target == TGT_TIME);
                            set_date  <= (edit_target == TGT_DATE);
                            set_alarm <= (edit_target == TGT_ALARM);
                            set_timer <= (edit_target == TGT_TIMER);
                            if (edit_target == TGT_ALARM) begin
                                alarm_time_hour <= input_hour;
                                alarm_time_min  <= input_min;
                                alarm_time_sec  <= input_sec;
                            end
                            if (edit_target == TGT_TIMER) begin
                                timer_input_min <= input_min;
                                timer_input_sec <= input_sec;
                            end
                        end else begin
                            edit_field <= edit_field + 2'd1;
                        end
                    end else if (btn_inc || btn_dec) begin
                        case (edit_target)
                            TGT_DATE: begin
                                case (edit_field)
                                    2'd0:    input_day   <= stepped[7:0];
                                    2'd1:    input_month <= stepped[7:0];
                                    default: input_year  <= stepped;
                                endcase
                            end
                            TGT_TIMER: begin
                                if (edit_field == 2'd0) input_min <= stepped[7:0];
                                else                    input_sec <= stepped[7:0];
                            end
                            default: begin
                                case (edit_field)
                                    2'd0:    input_hour <= stepped[7:0];
                                    2'd1:    input_min  <= stepped[7:0];
                                    default: input_sec  <= stepped[7:0];
                                endcase
                            end
                        endcase
                    end
                end
                COMMIT: begin
                    state      <= IDLE;
                    edit_field <= 2'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_settings_controller.sv
// Self-checking bench for settings_controller: directed scenarios followed by
// randomized button/live-value traffic, all compared to a table-driven model.
module tb_settings_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
    logic [7:0]  current_24_hour = 8'd0, current_24_min = 8'd0, current_24_sec = 8'd0;
    logic [7:0]  current_day = 8'd1, current_month = 8'd1;
    logic [15:0] current_year = 16'd2020;
    logic        set_time, set_date, set_alarm, set_timer;
    logic [7:0]  input_hour, input_min, input_sec, input_day, input_month;
    logic [15:0] input_year;
    logic [7:0]  alarm_time_hour, alarm_time_min, alarm_time_sec;
    logic [7:0]  timer_input_min, timer_input_sec;
    logic [1:0]  edit_target, edit_field;
    logic        editing;

    always #5 clk = ~clk;

    settings_controller dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .btn_cancel(btn_cancel),
        .current_24_hour(current_24_hour), .current_24_min(current_24_min),
        .current_24_sec(current_24_sec), .current_day(current_day),
        .current_month(current_month), .current_year(current_year),
        .set_time(set_time), .set_date(set_date), .set_alarm(set_alarm), .set_timer(set_timer),
        .input_hour(input_hour), .input_min(input_min), .input_sec(input_sec),
        .input_day(input_day), .input_month(input_month), .input_year(input_year),
        .alarm_time_hour(alarm_time_hour), .alarm_time_min(alarm_time_min),
        .alarm_time_sec(alarm_time_sec), .timer_input_min(timer_input_min),
        .timer_input_sec(timer_input_sec), .edit_target(edit_target),
        .edit_field(edit_field), .editing(editing)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. wk[] slots: 0 hour, 1 min, 2 sec, 3 day, 4 month, 5 year.
    // State codes: 0 idle, 1 select, 2 edit, 3 commit.
    int m_state, m_tgt, m_fld;
    int wk [6];
    int alarm [3];
    int timer [2];
    int strobe [4];
    int lo_t  [4][3] = '{'{0, 0, 0}, '{1, 1, 2000}, '{0, 0, 0}, '{0, 0, 0}};
    int hi_t  [4][3] = '{'{23, 59, 59}, '{31, 12, 2099}, '{23, 59, 59}, '{10, 59, 0}};
    int idx_t [4][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{0, 1, 2}, '{1, 2, 0}};
    int nf_t  [4]    = '{3, 3, 3, 2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_tgt = 0; m_fld = 0;
        wk = '{0, 0, 0, 1, 1, 2020};
        alarm = '{0, 0, 0};
        timer = '{0, 0};
        strobe = '{0, 0, 0, 0};
    endtask

    task automatic model_adjust(input int delta);
        int k, v, lo, hi, n;
        k  = idx_t[m_tgt][m_fld];
        lo = lo_t[m_tgt][m_fld];
        hi = hi_t[m_tgt][m_fld];
        n  = hi - lo + 1;
        v  = wk[k];
        if (v < lo || v > hi) v = hi;
        else                  v = lo + (v - lo + delta + n) % n;
        wk[k] = v;
    endtask

    task automatic model_update(input logic m, input logic n, input logic i,
                                input logic d, input logic c, input logic r);
        strobe = '{0, 0, 0, 0};
        if (r) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (m) begin m_state = 1; m_tgt = 0; m_fld = 0; end
            1: begin
                if (c) m_state = 0;
                else if (n) begin
                    case (m_tgt)
                        0: begin wk[0] = current_24_hour; wk[1] = current_24_min; wk[2] = current_24_sec; end
                        1: begin wk[3] = current_day; wk[4] = current_month; wk[5] = current_year; end
                        2: begin wk[0] = alarm[0]; wk[1] = alarm[1]; wk[2] = alarm[2]; end
                        default: begin wk[1] = timer[0]; wk[2] = timer[1]; end
                    endcase
                    m_state = 2; m_fld = 0;
                end else if (m) m_tgt = (m_tgt + 1) % 4;
            end
            2: begin
                if (c) begin m_state = 0; m_fld = 0; end
                else if (n) begin
                    if (m_fld == nf_t[m_tgt] - 1) begin
                        m_state = 3;
                        strobe[m_tgt] = 1;
                        if (m_tgt == 2) begin alarm[0] = wk[0]; alarm[1] = wk[1]; alarm[2] = wk[2]; end
                        if (m_tgt == 3) begin timer[0] = wk[1]; timer[1] = wk[2]; end
                    end else m_fld++;
                end
                else if (i) model_adjust(1);
                else if (d) model_adjust(-1);
            end
            default: begin m_state = 0; m_fld = 0; end
        endcase
    endtask

    task automatic check_all();
        check("editing", editing, (m_state == 1 || m_state == 2));
        check("edit_target", edit_target, m_tgt);
        check("edit_field", edit_field, m_fld);
        check("set_time", set_time, strobe[0]);
        check("set_date", set_date, strobe[1]);
        check("set_alarm", set_alarm, strobe[2]);
        check("set_timer", set_timer, strobe[3]);
        check("input_hour", input_hour, wk[0]);
        check("input_min", input_min, wk[1]);
        check("input_sec", input_sec, wk[2]);
        check("input_day", input_day, wk[3]);
        check("input_month", input_month, wk[4]);
        check("input_year", input_year, wk[5]);
        check("alarm_hour", alarm_time_hour, alarm[0]);
        check("alarm_min", alarm_time_min, alarm[1]);
        check("alarm_sec", alarm_time_sec, alarm[2]);
        check("timer_min", timer_input_min, timer[0]);
        check("timer_sec", timer_input_sec, timer[1]);
    endtask

    // Drive one cycle of buttons at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic m, input logic n, input logic i,
                        input logic d, input logic c, input logic r);
        @(negedge clk);
        btn_mode = m; btn_next = n; btn_inc = i; btn_dec = d; btn_cancel = c; reset = r;
        @(posedge clk);
        #1;
        model_update(m, n, i, d, c, r);
        check_all();
    endtask

    task automatic mode();  step(1, 0, 0, 0, 0, 0); endtask
    task automatic next();  step(0, 1, 0, 0, 0, 0); endtask
    task automatic inc();   step(0, 0, 1, 0, 0, 0); endtask
    task automatic dec();   step(0, 0, 0, 1, 0, 0); endtask
    task automatic idle();  step(0, 0, 0, 0, 0, 0); endtask

    function automatic logic [7:0] live8(input int hi);
        if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 255));
        return 8'($urandom_range(0, hi));
    endfunction

    initial begin
        model_reset();
        step(0, 0, 0, 0, 0, 1);
        check("reset_year", input_year, 2020);
        check("reset_day", input_day, 1);
        idle();

        // TIME: 0+11 on hour, 0-1 wraps min to 59, then commit.
        mode(); next();
        repeat (11) inc();
        next(); dec(); next(); next();
        check("t1_set_time", set_time, 1);
        check("t1_hour", input_hour, 11);
        check("t1_min", input_min, 59);
        check("t1_sec", input_sec, 0);
        idle();
        check("t1_strobe_one_cycle", set_time, 0);

        // DATE: year 2099 wraps to 2000.
        current_day = 8'd31; current_month = 8'd12; current_year = 16'd2099;
        mode(); mode(); next(); next(); next(); inc();
        check("t2_year_wrap", input_year, 2000);
        next();
        check("t2_set_date", set_date, 1);
        check("t2_commit_year", input_year, 2000);
        idle();

        // TIMER: min 0-1 wraps to 10, sec 0+5.
        mode(); mode(); mode(); mode(); next(); dec(); next();
        repeat (5) inc();
        next();
        check("t3_set_timer", set_timer, 1);
        check("t3_timer_min", timer_input_min, 10);
        check("t3_timer_sec", timer_input_sec, 5);
        idle();

        // ALARM 06:30:00 then cancel together with next on sec.
        mode(); mode(); mode(); next();
        repeat (6) inc();
        next();
        repeat (30) inc();
        next();
        step(0, 1, 0, 0, 1, 0);
        check("t4_editing", editing, 0);
        check("t4_set_alarm", set_alarm, 0);
        check("t4_alarm_hour", alarm_time_hour, 0);
        check("t4_alarm_min", alarm_time_min, 0);
        idle();

        // Reset in the COMMIT cycle: strobe drops, everything back to reset values.
        mode(); mode(); mode(); mode(); next(); next(); next();
        check("t5_strobe_before_reset", set_timer, 1);
        step(0, 0, 0, 0, 0, 1);
        check("t5_strobe_cleared", set_timer, 0);
        check("t5_timer_min", timer_input_min, 0);
        check("t5_year", input_year, 2020);
        idle();

        // inc+dec together counts as inc; mode during EDIT changes nothing.
        current_24_hour = 8'd5; current_24_min = 8'd7; current_24_sec = 8'd9;
        mode(); next();
        step(0, 0, 1, 1, 0, 0);
        check("t6_inc_dec", input_hour, 6);
        mode();
        check("t7_mode_target", edit_target, 0);
        check("t7_mode_hour", input_hour, 6);
        step(0, 0, 0, 0, 1, 0);

        // Out-of-range preload clamps to max on first dec.
        current_24_hour = 8'd200;
        mode(); next(); dec();
        check("t8_clamp", input_hour, 23);
        step(0, 0, 0, 0, 1, 0);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            current_24_hour = live8(23);
            current_24_min  = live8(59);
            current_24_sec  = live8(59);
            current_day     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 31));
            current_month   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 12));
            current_year    = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(2000, 2099));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
